// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Default sizes, the hardwired zero register and the pend_cnt width.
package rf_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rf_wr_arbiter.sv
// Resolves which write port, if any, targets one register address.
// The highest-index enabled port wins when several collide.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int AW  = 5,
  parameter int NWR = 2,
  parameter int PW  = 1
) (
  input  logic [AW-1:0]     i_addr,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  output logic              o_hit,
  output logic [PW-1:0]     o_port
);

  // Later ports overwrite earlier matches, giving high-index priority
  always_comb begin
    o_hit  = 1'b0;
    o_port = '0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_port = PW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write bypass
// and per-register pending bits used for decode hazard stalls.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*AW-1:0]       rd_addr,
  output logic [NRD*XLEN-1:0]     rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*AW-1:0]       wr_addr,
  input  logic [NWR*XLEN-1:0]     wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic [cnt_w(NREG)-1:0]  pend_cnt
);

  localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int CW = cnt_w(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_pend;
  logic [CW-1:0]   r_pend_cnt;

  logic            w_hit  [NREG];
  logic [PW-1:0]   w_port [NREG];
  logic [NREG-1:0] w_pend_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  logic [AW-1:0]   w_ra      [NRD];
  logic            w_rd_hit  [NRD];
  logic [PW-1:0]   w_rd_port [NRD];
  logic            w_byp     [NRD];

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign w_hit[r]  = 1'b0;
      assign w_port[r] = '0;
    end else begin : g_arb
      rf_wr_arbiter #(
        .AW (AW),
        .NWR(NWR),
        .PW (PW)
      ) u_arb (
        .i_addr   (AW'(r)),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_addr),
        .o_hit    (w_hit[r]),
        .o_port   (w_port[r])
      );
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign w_ra[i] = rd_addr[i*AW +: AW];

    rf_wr_arbiter #(
      .AW (AW),
      .NWR(NWR),
      .PW (PW)
    ) u_arb (
      .i_addr   (w_ra[i]),
      .i_wr_en  (wr_en),
      .i_wr_addr(wr_addr),
      .o_hit    (w_rd_hit[i]),
      .o_port   (w_rd_port[i])
    );

    assign w_byp[i] = (BYPASS != 0) && w_rd_hit[i];

    assign rd_data[i*XLEN +: XLEN] =
      (reset || (w_ra[i] == AW'(ZERO_REG))) ? '0 :
      w_byp[i] ? wr_data[w_rd_port[i]*XLEN +: XLEN] :
      r_mem[w_ra[i]];

    assign rd_busy[i] = !reset
                      && (w_ra[i] != AW'(ZERO_REG))
                      && r_pend[w_ra[i]]
                      && !w_byp[i];
  end

  // Next pending bits (a new issue beats a retiring write) and their popcount
  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = '0;
    for (int r = 0; r < NREG; r++) begin
      if (r == ZERO_REG) begin
        w_pend_nxt[r] = 1'b0;
      end else if (iss_en && (iss_addr == AW'(r))) begin
        w_pend_nxt[r] = 1'b1;
      end else if (w_hit[r]) begin
        w_pend_nxt[r] = 1'b0;
      end
      w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[r]);
    end
  end

  // Array, pending bits and count update; reset discards writes and issues
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_hit[r]) r_mem[r] <= wr_data[w_port[r]*XLEN +: XLEN];
      end
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign pend_cnt = r_pend_cnt;

endmodule
